alif_array: RTL and testbench

ALIF_ARRAY -- requirements
Module: alif_array

---
 rtl/alif_pkg.sv | 38 +++
 rtl/alif_update.sv | 71 +++++++
 rtl/alif_array.sv | 157 +++++++++++++++
 tb/tb_alif_array.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alif_pkg.sv
// alif_pkg -- shared constants and arithmetic helpers for the ALIF neuron array.
//
// Holds the default parameter values used by alif_array and alif_update, plus
// the saturating-add and floored-decay helpers used for the adaptive threshold.
// The helpers work on 32-bit containers; callers zero-extend their operands and
// truncate the result back to their own width.
package alif_pkg;

  localparam int unsigned DEF_N_NEURONS   = 4;
  localparam int unsigned DEF_WIDTH       = 8;
  localparam int unsigned DEF_LEAK_SHIFT  = 3;
  localparam int unsigned DEF_BASE_THETA  = 100;
  localparam int unsigned DEF_THETA_STEP  = 40;
  localparam int unsigned DEF_THETA_DECAY = 1;
  localparam int unsigned DEF_REFRAC_STEPS = 2;

  // a + b, clamped to 2^width - 1.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned width);
    logic [32:0] sum;
    logic [32:0] max_val;
    sum     = {1'b0, a} + {1'b0, b};
    max_val = (33'd1 << width) - 33'd1;
    return (sum > max_val) ? max_val[31:0] : sum[31:0];
  endfunction

  // max(a - dec, floor_val) without ever wrapping below zero.
  function automatic logic [31:0] decay_floor(input logic [31:0] a,
                                              input logic [31:0] dec,
                                              input logic [31:0] floor_val);
    if ({1'b0, a} >= ({1'b0, floor_val} + {1'b0, dec})) begin
      return a - dec;
    end
    return floor_val;
  endfunction

endpackage

// File: rtl/alif_update.sv
// alif_update -- combinational single-neuron adaptive LIF update.
//
// Ports:
//   refrac_i / refrac_o  refractory down-counter in/out (only with ALIF_REFRACTORY_EN)
//   v_i, theta_i         current membrane potential and threshold
//   cur_i                synaptic input current for this update
//   v_o, theta_o         next membrane potential and threshold
//   spike_o              neuron fires on this update
//
// Build option: ALIF_REFRACTORY_EN adds the refractory counter; a neuron with a
// non-zero count ignores its input, holds v at 0 and lets its threshold decay.
module alif_update
  import alif_pkg::*;
#(
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned LEAK_SHIFT   = DEF_LEAK_SHIFT,
  parameter int unsigned BASE_THETA   = DEF_BASE_THETA,
  parameter int unsigned THETA_STEP   = DEF_THETA_STEP,
`ifdef ALIF_REFRACTORY_EN
  parameter int unsigned REFRAC_STEPS = DEF_REFRAC_STEPS,
  parameter int unsigned RW           = 2,
`endif
  parameter int unsigned THETA_DECAY  = DEF_THETA_DECAY
) (
`ifdef ALIF_REFRACTORY_EN
  input  logic [RW-1:0]    refrac_i,
  output logic [RW-1:0]    refrac_o,
`endif
  input  logic [WIDTH-1:0] v_i,
  input  logic [WIDTH-1:0] theta_i,
  input  logic [WIDTH-1:0] cur_i,
  output logic [WIDTH-1:0] v_o,
  output logic [WIDTH-1:0] theta_o,
  output logic             spike_o
);

  logic [WIDTH-1:0] leaked;
  logic [WIDTH:0]   v_sum;
  logic [WIDTH-1:0] v_next;
  logic [WIDTH-1:0] theta_up;
  logic [WIDTH-1:0] theta_dn;

  // v - (v >> LEAK_SHIFT) never underflows, so only the add needs the extra bit.
  assign leaked   = v_i - (v_i >> LEAK_SHIFT);
  assign v_sum    = {1'b0, leaked} + {1'b0, cur_i};
  assign v_next   = v_sum[WIDTH] ? {WIDTH{1'b1}} : v_sum[WIDTH-1:0];
  assign theta_up = WIDTH'(sat_add(32'(theta_i), 32'(THETA_STEP), WIDTH));
  assign theta_dn = WIDTH'(decay_floor(32'(theta_i), 32'(THETA_DECAY), 32'(BASE_THETA)));

  always_comb begin
    v_o      = v_next;
    theta_o  = theta_dn;
    spike_o  = 1'b0;
`ifdef ALIF_REFRACTORY_EN
    refrac_o = '0;
    if (refrac_i != '0) begin
      v_o      = '0;
      refrac_o = refrac_i - RW'(1);
    end else
`endif
    if (v_next >= theta_i) begin
      v_o      = '0;
      theta_o  = theta_up;
      spike_o  = 1'b1;
`ifdef ALIF_REFRACTORY_EN
      refrac_o = RW'(REFRAC_STEPS);
`endif
    end
  end

endmodule

// File: rtl/alif_array.sv
// alif_array -- time-multiplexed array of adaptive LIF neurons.
//
// One input beat updates the neuron selected by an internal index, which then
// advances and wraps at N_NEURONS-1. Results sit in a single output register
// that can be refilled in the same cycle it drains.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         input current handshake, in_current = current
//   out_valid/out_ready       result handshake
//   out_idx, out_spike,       neuron index, fire flag, threshold after update,
//   out_theta, out_last       and end-of-timestep marker (index N_NEURONS-1)
//
// Build option: ALIF_REFRACTORY_EN enables per-neuron refractory counters.
module alif_array
  import alif_pkg::*;
#(
  parameter int unsigned N_NEURONS    = DEF_N_NEURONS,
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned LEAK_SHIFT   = DEF_LEAK_SHIFT,
  parameter int unsigned BASE_THETA   = DEF_BASE_THETA,
  parameter int unsigned THETA_STEP   = DEF_THETA_STEP,
  parameter int unsigned THETA_DECAY  = DEF_THETA_DECAY,
  parameter int unsigned REFRAC_STEPS = DEF_REFRAC_STEPS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_current,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(N_NEURONS)-1:0] out_idx,
  output logic                         out_spike,
  output logic [WIDTH-1:0]             out_theta,
  output logic                         out_last
);

  localparam int unsigned IDX_W = $clog2(N_NEURONS);

  logic [WIDTH-1:0] v_q     [N_NEURONS];
  logic [WIDTH-1:0] v_d     [N_NEURONS];
  logic [WIDTH-1:0] theta_q [N_NEURONS];
  logic [WIDTH-1:0] theta_d [N_NEURONS];
  logic [IDX_W-1:0] idx_q, idx_d;

  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             out_spike_q, out_spike_d;
  logic [WIDTH-1:0] out_theta_q, out_theta_d;
  logic             out_last_q, out_last_d;

  logic             accept;
  logic             idx_at_end;
  logic [WIDTH-1:0] upd_v, upd_theta;
  logic             upd_spike;

`ifdef ALIF_REFRACTORY_EN
  localparam int unsigned RW = (REFRAC_STEPS < 1) ? 1 : $clog2(REFRAC_STEPS + 1);
  logic [RW-1:0] refrac_q [N_NEURONS];
  logic [RW-1:0] refrac_d [N_NEURONS];
  logic [RW-1:0] upd_refrac;
`endif

  assign in_ready   = !out_valid_q || out_ready;
  assign accept     = in_valid && in_ready;
  assign idx_at_end = (idx_q == IDX_W'(N_NEURONS - 1));

  alif_update #(
    .WIDTH        (WIDTH),
    .LEAK_SHIFT   (LEAK_SHIFT),
    .BASE_THETA   (BASE_THETA),
    .THETA_STEP   (THETA_STEP),
`ifdef ALIF_REFRACTORY_EN
    .REFRAC_STEPS (REFRAC_STEPS),
    .RW           (RW),
`endif
    .THETA_DECAY  (THETA_DECAY)
  ) u_update (
`ifdef ALIF_REFRACTORY_EN
    .refrac_i (refrac_q[idx_q]),
    .refrac_o (upd_refrac),
`endif
    .v_i      (v_q[idx_q]),
    .theta_i  (theta_q[idx_q]),
    .cur_i    (in_current),
    .v_o      (upd_v),
    .theta_o  (upd_theta),
    .spike_o  (upd_spike)
  );

  always_comb begin
    v_d         = v_q;
    theta_d     = theta_q;
`ifdef ALIF_REFRACTORY_EN
    refrac_d    = refrac_q;
`endif
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_spike_d = out_spike_q;
    out_theta_d = out_theta_q;
    out_last_d  = out_last_q;
    if (accept) begin
      v_d[idx_q]     = upd_v;
      theta_d[idx_q] = upd_theta;
`ifdef ALIF_REFRACTORY_EN
      refrac_d[idx_q] = upd_refrac;
`endif
      idx_d       = idx_at_end ? '0 : idx_q + IDX_W'(1);
      out_valid_d = 1'b1;
      out_idx_d   = idx_q;
      out_spike_d = upd_spike;
      out_theta_d = upd_theta;
      out_last_d  = idx_at_end;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v_q[i]     <= '0;
        theta_q[i] <= WIDTH'(BASE_THETA);
`ifdef ALIF_REFRACTORY_EN
        refrac_q[i] <= '0;
`endif
      end
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_spike_q <= 1'b0;
      out_theta_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      v_q         <= v_d;
      theta_q     <= theta_d;
`ifdef ALIF_REFRACTORY_EN
      refrac_q    <= refrac_d;
`endif
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_spike_q <= out_spike_d;
      out_theta_q <= out_theta_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_spike = out_spike_q;
  assign out_theta = out_theta_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_alif_array.sv
module tb_alif_array;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_current;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_idx;
  logic       out_spike;
  logic [7:0] out_theta;
  logic       out_last;

  int checks = 0;
  int errors = 0;

  // Reference model state: plain integers following the neuron rules.
  int m_v [N];
  int m_theta [N];
  int m_refrac [N];
  int m_idx;

  alif_array dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_current (in_current),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_spike  (out_spike),
    .out_theta  (out_theta),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_v[i] = 0;
      m_theta[i] = 100;
      m_refrac[i] = 0;
    end
    m_idx = 0;
  endfunction

  function automatic void model_step(input int cur, output int sp, output int th,
                                     output int ix, output int lst);
    int i;
    int vn;
    i   = m_idx;
    ix  = i;
    lst = (i == N - 1) ? 1 : 0;
    sp  = 0;
`ifdef ALIF_REFRACTORY_EN
    if (m_refrac[i] > 0) begin
      m_v[i] = 0;
      m_refrac[i] = m_refrac[i] - 1;
      m_theta[i] = (m_theta[i] - 1 < 100) ? 100 : m_theta[i] - 1;
    end else
`endif
    begin
      vn = m_v[i] - m_v[i] / 8 + cur;
      if (vn > 255) vn = 255;
      if (vn >= m_theta[i]) begin
        sp = 1;
        m_v[i] = 0;
        m_theta[i] = (m_theta[i] + 40 > 255) ? 255 : m_theta[i] + 40;
        m_refrac[i] = 2;
      end else begin
        m_v[i] = vn;
        m_theta[i] = (m_theta[i] - 1 < 100) ? 100 : m_theta[i] - 1;
      end
    end
    th = m_theta[i];
    m_idx = (i + 1) % N;
  endfunction

  // Drives one beat with out_ready=1 and returns what the output register shows
  // afterwards; ok=0 means the beat was never accepted within the cycle budget.
  task automatic beat(input logic [7:0] cur, output logic sp, output logic [7:0] th,
                      output logic [1:0] ix, output logic lst, output bit ok);
    int n;
    ok = 1'b0;
    in_valid = 1'b1;
    in_current = cur;
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (in_ready) begin
      @(posedge clk); #1;
      ok = out_valid;
    end
    in_valid = 1'b0;
    sp  = out_spike;
    th  = out_theta;
    ix  = out_idx;
    lst = out_last;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic sp, lst; logic [7:0] th; logic [1:0] ix; bit ok;
    int esp, eth, eix, elst;
    logic [7:0] c;
    out_ready = 1'b0;
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_theta !== 8'd0 || out_spike !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got valid=%0b ready=%0b theta=%0d spike=%0b, want 0 1 0 0",
               out_valid, in_ready, out_theta, out_spike);
    end
    rst = 1'b0;
    model_reset();
    c = 8'($urandom_range(0, 255));
    beat(c, sp, th, ix, lst, ok);
    model_step(int'(c), esp, eth, eix, elst);
    checks++;
    if (!ok || ix !== 2'd0 || sp !== (esp != 0) || th !== 8'(eth) || lst !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_beat: got ok=%0b idx=%0d spike=%0b theta=%0d last=%0b, want idx=0 spike=%0d theta=%0d last=0",
               ok, ix, sp, th, lst, esp, eth);
    end
  endtask

  task automatic test_leak_spike();
    logic sp, lst; logic [7:0] th; logic [1:0] ix; bit ok;
    int esp, eth, eix, elst;
    logic [7:0] c;
    do_reset(2);
    for (int step = 1; step <= 3; step++) begin
      for (int n = 0; n < N; n++) begin
        c = (n == 0) ? 8'd60 : 8'd0;
        beat(c, sp, th, ix, lst, ok);
        model_step(int'(c), esp, eth, eix, elst);
        checks++;
        if (!ok || sp !== (esp != 0) || th !== 8'(eth) || ix !== 2'(eix) || lst !== (elst != 0)) begin
          errors++;
          $display("FAIL leak_model s%0d n%0d: got spike=%0b theta=%0d idx=%0d last=%0b ok=%0b, want %0d %0d %0d %0d",
                   step, n, sp, th, ix, lst, ok, esp, eth, eix, elst);
        end
        if (step <= 2) begin
          checks++;
          if ((n == 0 && step == 1 && (sp !== 1'b0 || th !== 8'd100)) ||
              (n == 0 && step == 2 && (sp !== 1'b1 || th !== 8'd140)) ||
              (n != 0 && sp !== 1'b0)) begin
            errors++;
            $display("FAIL leak_directed s%0d n%0d: got spike=%0b theta=%0d", step, n, sp, th);
          end
        end
      end
    end
  endtask

  task automatic test_theta_sat();
    logic sp, lst; logic [7:0] th; logic [1:0] ix; bit ok;
    int esp, eth, eix, elst;
    logic [7:0] c;
`ifdef ALIF_REFRACTORY_EN
    int exp_sp [7] = '{1, 0, 0, 1, 0, 0, 1};
    int exp_th [7] = '{140, 139, 138, 178, 177, 176, 216};
`else
    int exp_sp [7] = '{1, 1, 1, 1, 1, 1, 1};
    int exp_th [7] = '{140, 180, 220, 255, 255, 255, 255};
`endif
    do_reset(2);
    for (int step = 0; step < 7; step++) begin
      for (int n = 0; n < N; n++) begin
        c = (n == 1) ? 8'd255 : 8'd0;
        beat(c, sp, th, ix, lst, ok);
        model_step(int'(c), esp, eth, eix, elst);
        checks++;
        if (!ok || sp !== (esp != 0) || th !== 8'(eth) || ix !== 2'(eix) || lst !== (elst != 0)) begin
          errors++;
          $display("FAIL theta_model s%0d n%0d: got spike=%0b theta=%0d idx=%0d last=%0b ok=%0b, want %0d %0d %0d %0d",
                   step, n, sp, th, ix, lst, ok, esp, eth, eix, elst);
        end
        if (n == 1) begin
          checks++;
          if (sp !== (exp_sp[step] != 0) || th !== 8'(exp_th[step])) begin
            errors++;
            $display("FAIL theta_directed s%0d: got spike=%0b theta=%0d, want spike=%0d theta=%0d",
                     step + 1, sp, th, exp_sp[step], exp_th[step]);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic sp, lst; logic [7:0] th; logic [1:0] ix; bit ok;
    int esp, eth, eix, elst;
    logic [7:0] c0, c1, c;
    do_reset(1);
    c0 = 8'($urandom_range(0, 255));
    c1 = 8'($urandom_range(0, 255));
    in_valid = 1'b1;
    in_current = c0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    model_step(int'(c0), esp, eth, eix, elst);
    in_current = c1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_idx !== 2'd0 ||
          out_spike !== (esp != 0) || out_theta !== 8'(eth) || out_last !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold c%0d: got ready=%0b valid=%0b idx=%0d spike=%0b theta=%0d last=%0b, want 0 1 0 %0d %0d 0",
                 k, in_ready, out_valid, out_idx, out_spike, out_theta, out_last, esp, eth);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_step(int'(c1), esp, eth, eix, elst);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 2'd1 || out_spike !== (esp != 0) ||
        out_theta !== 8'(eth) || out_last !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: got valid=%0b idx=%0d spike=%0b theta=%0d last=%0b, want 1 1 %0d %0d 0",
               out_valid, out_idx, out_spike, out_theta, out_last, esp, eth);
    end
    for (int b = 0; b < 6; b++) begin
      c = 8'($urandom_range(0, 255));
      beat(c, sp, th, ix, lst, ok);
      model_step(int'(c), esp, eth, eix, elst);
      checks++;
      if (!ok || sp !== (esp != 0) || th !== 8'(eth) || ix !== 2'(eix) || lst !== (ix == 2'd3)) begin
        errors++;
        $display("FAIL stall_after b%0d: got spike=%0b theta=%0d idx=%0d last=%0b ok=%0b, want %0d %0d %0d %0d",
                 b, sp, th, ix, lst, ok, esp, eth, eix, elst);
      end
    end
  endtask

  task automatic test_random();
    logic sp, lst; logic [7:0] th; logic [1:0] ix; bit ok;
    int esp, eth, eix, elst;
    logic [7:0] c;
    do_reset(1);
    for (int b = 0; b < 64; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_current = 8'($urandom_range(0, 255));
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      c = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40));
      beat(c, sp, th, ix, lst, ok);
      model_step(int'(c), esp, eth, eix, elst);
      checks++;
      if (!ok || sp !== (esp != 0) || th !== 8'(eth) || ix !== 2'(eix) || lst !== (elst != 0)) begin
        errors++;
        $display("FAIL random b%0d cur=%0d: got spike=%0b theta=%0d idx=%0d last=%0b ok=%0b, want %0d %0d %0d %0d",
                 b, c, sp, th, ix, lst, ok, esp, eth, eix, elst);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic sp, lst; logic [7:0] th; logic [1:0] ix; bit ok;
    int esp, eth, eix, elst;
    do_reset(1);
    for (int b = 0; b < 2; b++) begin
      beat(8'd255, sp, th, ix, lst, ok);
      model_step(255, esp, eth, eix, elst);
      checks++;
      if (!ok || sp !== (esp != 0) || th !== 8'(eth) || ix !== 2'(eix)) begin
        errors++;
        $display("FAIL midrst_pre b%0d: got spike=%0b theta=%0d idx=%0d ok=%0b, want %0d %0d %0d",
                 b, sp, th, ix, ok, esp, eth, eix);
      end
    end
    in_valid = 1'b1;
    in_current = 8'd255;
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_flush: got valid=%0b ready=%0b, want 0 1", out_valid, in_ready);
    end
    for (int n = 0; n < N; n++) begin
      beat(8'd0, sp, th, ix, lst, ok);
      model_step(0, esp, eth, eix, elst);
      checks++;
      if (!ok || ix !== 2'(n) || th !== 8'd100 || sp !== 1'b0 || th !== 8'(eth) ||
          lst !== (elst != 0)) begin
        errors++;
        $display("FAIL midrst_post n%0d: got idx=%0d theta=%0d spike=%0b last=%0b ok=%0b, want %0d 100 0 %0d",
                 n, ix, th, sp, lst, ok, n, elst);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_current = 8'd0;
    out_ready = 1'b1;
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_leak_spike();
    test_theta_sat();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
